// File: rtl/gl_pkg.sv
// Shared GL command definitions: instruction word field positions, opcodes
// and the fetch FSM state encoding.
package gl_pkg;
    localparam int OPC_MSB  = 31;
    localparam int OPC_LSB  = 24;
    localparam int TYPE_BIT = 23;
    localparam int IMM_MSB  = 22;

    localparam logic [7:0] OP_NOP          = 8'h00;
    localparam logic [7:0] OP_VERTEX       = 8'h03;
    localparam logic [7:0] OP_COLOR        = 8'h04;
    localparam logic [7:0] OP_MATRIXMODE   = 8'h10;
    localparam logic [7:0] OP_LOADIDENTITY = 8'h11;
    localparam logic [7:0] OP_TRANSLATE    = 8'h12;
    localparam logic [7:0] OP_ROTATE       = 8'h13;
    localparam logic [7:0] OP_SCALE        = 8'h14;
    localparam logic [7:0] OP_PUSHMATRIX   = 8'h15;
    localparam logic [7:0] OP_POPMATRIX    = 8'h16;
    localparam logic [7:0] OP_BEGIN        = 8'h17;
    localparam logic [7:0] OP_END          = 8'h18;
    localparam logic [7:0] OP_ORTHO        = 8'h19;
    localparam logic [7:0] OP_FRUSTUM      = 8'h1A;
    localparam logic [7:0] OP_HALT         = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_ISSUE
    } fetch_state_t;
endpackage

// File: rtl/gl_fetch.sv
// GL command fetch/issue stage: reads words from instruction memory and holds each
// command on the decoder inputs until released. Optional icount via GL_FETCH_ICOUNT_EN.
module gl_fetch
    import gl_pkg::*;
#(
    parameter int         ADDR_W   = 10,
    parameter int         HOLD_MIN = 2,
    parameter logic [7:0] OP_NOP   = gl_pkg::OP_NOP,
    parameter logic [7:0] OP_HALT  = gl_pkg::OP_HALT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    output logic [ADDR_W-1:0] imem_addr,
    output logic              imem_en,
    input  logic [31:0]       imem_data,
    output logic [7:0]        opcode,
    output logic              cmd_type,
    output logic [22:0]       imm,
    output logic [31:0]       bram_addr_out,
    input  logic              stall,
    output logic              busy,
    output logic              done
`ifdef GL_FETCH_ICOUNT_EN
    ,
    output logic [31:0]       icount
`endif
);
    localparam int HCW = $clog2(HOLD_MIN + 1);

    fetch_state_t      state, state_d;
    logic [ADDR_W-1:0] pc, pc_d;
    logic [HCW-1:0]    hold_cnt, hold_d;
    logic [7:0]        opc_d;
    logic              type_d;
    logic [22:0]       imm_d;
    logic              busy_d, done_d;
    logic              release_cmd;

    // Memory is read while in FETCH so the word arrives during WAIT.
    assign imem_en       = (state == ST_FETCH);
    assign imem_addr     = pc;
    assign bram_addr_out = {9'b0, imm};

    // Stall is only honoured once the command has been shown HOLD_MIN cycles.
    assign release_cmd = (state == ST_ISSUE) && (hold_cnt >= HCW'(HOLD_MIN)) && !stall;

    always_comb begin
        state_d = state;
        pc_d    = pc;
        hold_d  = hold_cnt;
        opc_d   = opcode;
        type_d  = cmd_type;
        imm_d   = imm;
        busy_d  = busy;
        done_d  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    pc_d    = start_addr;
                    busy_d  = 1'b1;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: state_d = ST_WAIT;
            ST_WAIT: begin
                if (imem_data[OPC_MSB:OPC_LSB] == OP_HALT) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    opc_d   = OP_NOP;
                    state_d = ST_IDLE;
                end else begin
                    opc_d   = imem_data[OPC_MSB:OPC_LSB];
                    type_d  = imem_data[TYPE_BIT];
                    imm_d   = imem_data[IMM_MSB:0];
                    hold_d  = HCW'(1);
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (hold_cnt < HCW'(HOLD_MIN))
                    hold_d = hold_cnt + 1'b1;
                if (release_cmd) begin
                    opc_d   = OP_NOP;
                    pc_d    = pc + 1'b1;
                    state_d = ST_FETCH;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            pc       <= '0;
            hold_cnt <= '0;
            opcode   <= OP_NOP;
            cmd_type <= 1'b0;
            imm      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_d;
            pc       <= pc_d;
            hold_cnt <= hold_d;
            opcode   <= opc_d;
            cmd_type <= type_d;
            imm      <= imm_d;
            busy     <= busy_d;
            done     <= done_d;
        end
    end

`ifdef GL_FETCH_ICOUNT_EN
    always_ff @(posedge clk) begin
        if (rst || (state == ST_IDLE && start))
            icount <= '0;
        else if (release_cmd)
            icount <= icount + 32'd1;
    end
`endif
endmodule
